// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Opcode values, instruction field positions and the control
//                strobe bundle shared by the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Opcode values carried in instr[15:11]
    localparam logic [4:0] OP_HALT       = 5'b00000;
    localparam logic [2:0] OP_IMM_PREFIX = 3'b001;
    localparam logic [4:0] OP_FFT        = 5'b01000;
    localparam logic [4:0] OP_STORE      = 5'b01001;
    localparam logic [4:0] OP_ALU        = 5'b01010;
    localparam logic [4:0] OP_BRANCH     = 5'b01011;
    localparam logic [4:0] OP_SETFREQ    = 5'b01100;
    localparam logic [4:0] OP_SET        = 5'b01110;
    localparam logic [4:0] OP_SYN        = 5'b01111;

    // Instruction field positions
    localparam int c_INSTR_W    = 16;
    localparam int c_OP_LSB     = 11;
    localparam int c_OP_W       = 5;
    localparam int c_PREFIX_LSB = 13;
    localparam int c_PREFIX_W   = 3;
    localparam int c_SHIFT_LSB  = 11;
    localparam int c_SHIFT_W    = 2;
    localparam int c_IMM_LSB    = 0;
    localparam int c_IMM_W      = 11;
    localparam int c_RA_LSB     = 8;
    localparam int c_RB_LSB     = 5;

    // Control strobes produced by the opcode decoder
    typedef struct packed {
        logic halt;
        logic alu_op;
        logic reg_wr_en;
        logic mem_wr_en;
        logic branch;
        logic fft_wr_en;
        logic set_en;
        logic syn;
        logic use_imm;
        logic set_freq;
    } ctrl_t;

endpackage : decode_pkg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : General-purpose register file with two asynchronous read
//                ports, one synchronous write port, asynchronous clear and a
//                same-cycle write-through bypass on both read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int NUMREGISTERS = 8,
    parameter int DATAW        = 32,
    parameter int ADDRW        = $clog2(NUMREGISTERS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ADDRW-1:0] wr_addr,
    input  logic [DATAW-1:0] wr_data,
    input  logic [ADDRW-1:0] rd_addr_a,
    input  logic [ADDRW-1:0] rd_addr_b,
    output logic [DATAW-1:0] rd_data_a,
    output logic [DATAW-1:0] rd_data_b
);

    logic [DATAW-1:0] r_mem [NUMREGISTERS];
    logic             w_byp_a;
    logic             w_byp_b;

    // Storage: cleared asynchronously, written on the rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '{default: '0};
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Bypass is disabled under reset so both ports read the cleared value
    always_comb begin
        w_byp_a   = wr_en && !rst && (wr_addr == rd_addr_a);
        w_byp_b   = wr_en && !rst && (wr_addr == rd_addr_b);
        rd_data_a = w_byp_a ? wr_data : r_mem[rd_addr_a];
        rd_data_b = w_byp_b ? wr_data : r_mem[rd_addr_b];
    end

endmodule : reg_file
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode
//  Description : Pipeline decode stage. Reads two operands from the register
//                file, passes immediate and shift fields through and decodes
//                the 5-bit opcode into control strobes, all combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
    import decode_pkg::*;
#(
    parameter int NUMREGISTERS = 8,
    parameter int DATAW        = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [15:0]                     instr,
    input  logic                            reg_wr_en_in,
    input  logic [$clog2(NUMREGISTERS)-1:0] wr_reg,
    input  logic [DATAW-1:0]                wr_data,
    output logic [DATAW-1:0]                a,
    output logic [DATAW-1:0]                b,
    output logic [10:0]                     imm,
    output logic [1:0]                      shift_dist,
    output logic                            halt,
    output logic                            alu_op,
    output logic                            reg_wr_en_out,
    output logic                            mem_wr_en,
    output logic                            branch,
    output logic                            fft_wr_en,
    output logic                            set_en,
    output logic                            syn,
    output logic                            use_imm,
    output logic                            set_freq
);

    localparam int c_ADDRW = $clog2(NUMREGISTERS);

    logic [c_OP_W-1:0]     w_op;
    logic [c_PREFIX_W-1:0] w_prefix;
    logic [c_ADDRW-1:0]    w_ra;
    logic [c_ADDRW-1:0]    w_rb;
    ctrl_t                 w_ctrl;

    assign w_op       = instr[c_OP_LSB +: c_OP_W];
    assign w_prefix   = instr[c_PREFIX_LSB +: c_PREFIX_W];
    assign w_ra       = instr[c_RA_LSB +: c_ADDRW];
    assign w_rb       = instr[c_RB_LSB +: c_ADDRW];
    assign imm        = instr[c_IMM_LSB +: c_IMM_W];
    assign shift_dist = instr[c_SHIFT_LSB +: c_SHIFT_W];

    reg_file #(
        .NUMREGISTERS (NUMREGISTERS),
        .DATAW        (DATAW),
        .ADDRW        (c_ADDRW)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (reg_wr_en_in),
        .wr_addr   (wr_reg),
        .wr_data   (wr_data),
        .rd_addr_a (w_ra),
        .rd_addr_b (w_rb),
        .rd_data_a (a),
        .rd_data_b (b)
    );

    // Opcode decoder; unlisted opcodes leave every strobe low
    always_comb begin
        w_ctrl         = '0;
        w_ctrl.use_imm = (w_prefix == OP_IMM_PREFIX);
        case (w_op)
            OP_HALT:    w_ctrl.halt      = 1'b1;
            OP_FFT:     w_ctrl.fft_wr_en = 1'b1;
            OP_STORE:   w_ctrl.mem_wr_en = 1'b1;
            OP_ALU:     w_ctrl.alu_op    = 1'b1;
            OP_BRANCH:  w_ctrl.branch    = 1'b1;
            OP_SETFREQ: w_ctrl.set_freq  = 1'b1;
            OP_SET:     w_ctrl.set_en    = 1'b1;
            OP_SYN:     w_ctrl.syn       = 1'b1;
            default:    ;
        endcase
        w_ctrl.reg_wr_en = w_ctrl.use_imm | w_ctrl.alu_op;
    end

    assign halt          = w_ctrl.halt;
    assign alu_op        = w_ctrl.alu_op;
    assign reg_wr_en_out = w_ctrl.reg_wr_en;
    assign mem_wr_en     = w_ctrl.mem_wr_en;
    assign branch        = w_ctrl.branch;
    assign fft_wr_en     = w_ctrl.fft_wr_en;
    assign set_en        = w_ctrl.set_en;
    assign syn           = w_ctrl.syn;
    assign use_imm       = w_ctrl.use_imm;
    assign set_freq      = w_ctrl.set_freq;

endmodule : instr_decode
`default_nettype wire

// File: tb/tb_instr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_decode
//  Description : Self-checking bench for instr_decode with a behavioural
//                register/decode reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        reg_wr_en_in;
    logic [2:0]  wr_reg;
    logic [31:0] wr_data;
    logic [31:0] a, b;
    logic [10:0] imm;
    logic [1:0]  shift_dist;
    logic        halt, alu_op, reg_wr_en_out, mem_wr_en, branch;
    logic        fft_wr_en, set_en, syn, use_imm, set_freq;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [8];

    always #5 clk = ~clk;

    instr_decode #(.NUMREGISTERS(8), .DATAW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .reg_wr_en_in  (reg_wr_en_in),
        .wr_reg        (wr_reg),
        .wr_data       (wr_data),
        .a             (a),
        .b             (b),
        .imm           (imm),
        .shift_dist    (shift_dist),
        .halt          (halt),
        .alu_op        (alu_op),
        .reg_wr_en_out (reg_wr_en_out),
        .mem_wr_en     (mem_wr_en),
        .branch        (branch),
        .fft_wr_en     (fft_wr_en),
        .set_en        (set_en),
        .syn           (syn),
        .use_imm       (use_imm),
        .set_freq      (set_freq)
    );

    // Strobe order: halt alu reg_wr mem branch fft set_en syn use_imm set_freq
    function automatic logic [9:0] ref_strobes(input logic [15:0] ins);
        int op;
        logic h, al, rw, mw, br, ff, se, sy, ui, sf;
        op = int'(ins >> 11);
        h  = (op == 0);
        ui = (op >= 4) && (op <= 7);
        ff = (op == 8);
        mw = (op == 9);
        al = (op == 10);
        br = (op == 11);
        sf = (op == 12);
        se = (op == 14);
        sy = (op == 15);
        rw = ui || al;
        return {h, al, rw, mw, br, ff, se, sy, ui, sf};
    endfunction

    function automatic logic [9:0] dut_strobes();
        return {halt, alu_op, reg_wr_en_out, mem_wr_en, branch,
                fft_wr_en, set_en, syn, use_imm, set_freq};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input string tag);
        check({tag, ".strobes"}, 32'(dut_strobes()), 32'(ref_strobes(instr)));
        check({tag, ".imm"}, 32'(imm), 32'(instr % 2048));
        check({tag, ".shift"}, 32'(shift_dist), 32'((instr / 2048) % 4));
    endtask

    task automatic check_reads(input string tag);
        check({tag, ".a"}, a, model[(instr / 256) % 8]);
        check({tag, ".b"}, b, model[(instr / 32) % 8]);
    endtask

    task automatic write_reg(input int idx, input logic [31:0] val);
        reg_wr_en_in = 1'b1;
        wr_reg       = 3'(idx);
        wr_data      = val;
        @(posedge clk);
        #1;
        model[idx]   = val;
        reg_wr_en_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d [8];
        rst          = 1'b1;
        instr        = 16'h0000;
        reg_wr_en_in = 1'b0;
        wr_reg       = 3'd0;
        wr_data      = 32'h0;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;

        // Reset state
        #3;
        check_reads("reset");
        check_fields("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Reads after reset are all zero
        for (int i = 0; i < 8; i += 2) begin
            instr = 16'(16'h4000 | (i << 8) | ((i + 1) << 5));
            @(negedge clk);
            check("clr.a", a, 32'h0);
            check("clr.b", b, 32'h0);
            check_fields("clr");
        end

        // Write every register then read back in pairs
        for (int i = 0; i < 8; i++) begin
            d[i] = $urandom | 32'h1;
            write_reg(i, d[i]);
        end
        for (int i = 0; i < 8; i += 2) begin
            instr = 16'(16'h5000 | (i << 8) | ((i + 1) << 5));
            @(negedge clk);
            check("rb.a", a, d[i]);
            check("rb.b", b, d[i + 1]);
        end

        // Write-through bypass
        write_reg(3, 32'h11111111);
        instr        = 16'h5000 | (16'd3 << 8) | (16'd4 << 5);
        reg_wr_en_in = 1'b1;
        wr_reg       = 3'd3;
        wr_data      = 32'hDEADBEEF;
        #2;
        check("byp.a_pre", a, 32'hDEADBEEF);
        check("byp.b_other", b, model[4]);
        instr = 16'h5000 | (16'd3 << 8) | (16'd3 << 5);
        #1;
        check("byp.b_same", b, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        model[3]     = 32'hDEADBEEF;
        reg_wr_en_in = 1'b0;
        wr_data      = 32'h0;
        #2;
        check("byp.a_post", a, 32'hDEADBEEF);

        // Opcode sweep
        for (int op = 0; op < 32; op++) begin
            instr = 16'((op << 11) | 16'h05A3);
            #2;
            check_fields("sweep");
            check("sweep.imm_const", 32'(imm), 32'h5A3);
        end

        // Random regression
        for (int n = 0; n < 500; n++) begin
            instr = 16'($urandom);
            #2;
            check_fields("rand");
            if (n % 10 == 0) check_reads("rand");
        end

        // Fill registers, then reset asynchronously between edges
        for (int i = 0; i < 8; i++) write_reg(i, $urandom | 32'h80000000);
        instr = 16'h5000 | (16'd6 << 8) | (16'd7 << 5);
        @(posedge clk);
        #2;
        check_reads("prereset");
        rst = 1'b1;
        #1;
        check("arst.a", a, 32'h0);
        check("arst.b", b, 32'h0);
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        reg_wr_en_in = 1'b1;
        wr_reg       = 3'd6;
        wr_data      = 32'hCAFEF00D;
        #1;
        check("arst.byp_off", a, 32'h0);
        reg_wr_en_in = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i += 2) begin
            instr = 16'(16'h5000 | (i << 8) | ((i + 1) << 5));
            @(negedge clk);
            check_reads("postrst");
        end
        write_reg(5, 32'h0BADC0DE);
        instr = 16'h5000 | (16'd5 << 8) | (16'd4 << 5);
        #2;
        check_reads("rewrite");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instr_decode
`default_nettype wire
